prior_som: RTL and testbench
============================

Name: prior_som

Overview:
- Audio-source priority selector for a home sound system.
- Two asynchronous request inputs (A, B) choose which single device drives the speaker: PC, ALEXA or TV (the default).
- Outputs are one-hot registered enables that feed the downstream audio mux.
- A minimum dwell time stops rapid source flapping.

Parameters:
- HOLD_CYCLES, 4: minimum clock cycles a newly selected source stays active before another change is accepted. 0 means change immediately. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  1  PC audio request, asynchronous to clk, highest priority.
- B  input  1  ALEXA audio request, asynchronous to clk.
- TV  output  1  TV source enable, registered.
- PC  output  1  PC source enable, registered.
- ALEXA  output  1  ALEXA source enable, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): state=TV, TV=1, PC=0, ALEXA=0, hold counter=0, synchronizer flops=0. Reset applied mid-operation takes effect immediately, regardless of the hold count.
- Synchronization: A and B each pass through a 2-flop synchronizer, producing A_s and B_s.
- Target decode from synchronized inputs:
  - A_s=1 selects PC, whatever B_s is.
  - A_s=0 and B_s=1 selects ALEXA.
  - A_s=0 and B_s=0 selects TV.
- Truth table on (A,B): 00→TV, 01→ALEXA, 10→PC, 11→PC.
- State machine has three states, TV, PC and ALEXA. Outputs are driven directly from the state register, one-hot. Exactly one output is high at all times, including during and after reset.
- Transition rule: on a rising edge, if target≠state and hold counter==0, then state←target and hold counter←HOLD_CYCLES. Otherwise state is unchanged.
- Hold counter decrements by 1 each cycle while nonzero and saturates at 0. Requests arriving during the hold are not latched. After the hold, the current target is re-evaluated, so a request that went away during the hold is ignored.
- Latency: with the counter at 0 and an input stable before rising edge k, the outputs change at edge k+2 (3 edges total: 2 synchronizer stages plus the state register).
- A target equal to the current state causes no reload of the counter.
- Input glitches narrower than one clock period may or may not be captured. No debouncing beyond the dwell time is required.

Optional Feature:
- Macro: PRIOR_SOM_STATUS_EN.
- When defined, two extra output ports are added:
  - sel, 2 bits: state code, 00=TV, 01=PC, 10=ALEXA. Never 11. Reset value 00.
  - switch_cnt, 8 bits: count of accepted source changes, saturating at 255. Reset value 0. It increments on the same edge as the state change.
- When undefined, these ports and their logic are absent, and TV/PC/ALEXA behaviour is identical in both builds.

Decomposition:
- Package prior_som_pkg holds:
  - typedef enum logic [1:0] src_e: SRC_TV=2'b00, SRC_PC=2'b01, SRC_ALEXA=2'b10.
  - localparam HOLD_CYCLES_DEFAULT=4.
- One sub-module, prior_som_sync: a parameterized-width 2-flop synchronizer with async active-low reset, instantiated with width 2 for {A,B}.

Test Plan:
- Reset: assert rst_n=0 mid-run while PC=1 → TV=1, PC=0, ALEXA=0 at once, without waiting for a clock edge. sel=00 and switch_cnt=0 when the feature is enabled.
- Truth table, HOLD_CYCLES=4, each input held 20 cycles: (A,B)=00→TV only; 01→ALEXA only; 10→PC only; 11→PC only. Check the one-hot invariant every cycle.
- Latency: from idle TV, set A=1 before edge k → PC=1 and TV=0 first at edge k+2, not at k+1.
- Dwell: switch to ALEXA, then set A=1 one cycle after the switch → PC is not asserted until the 4-cycle hold expires, then follows after the normal 2-edge pipeline.
- Dropped request: go TV→ALEXA, pulse A high for 2 cycles inside the hold, then hold A=0 and B=1 → ALEXA stays selected and switch_cnt increments only once.
- HOLD_CYCLES=0 with alternating 01/10 every 3 cycles → output follows each change with 2-edge latency. switch_cnt saturates at 255 after 300 changes when the feature is enabled.

Source files
------------

// File: rtl/prior_som_pkg.sv
// rtl/prior_som_pkg.sv - shared source codes and defaults for the audio source selector
package prior_som_pkg;

  typedef enum logic [1:0] {
    SRC_TV    = 2'b00,
    SRC_PC    = 2'b01,
    SRC_ALEXA = 2'b10
  } src_e;

  localparam int HOLD_CYCLES_DEFAULT = 4;

  // PC request dominates; ALEXA only when PC is idle; TV otherwise.
  function automatic src_e decode_target(input logic a_s, input logic b_s);
    if (a_s) begin
      return SRC_PC;
    end else if (b_s) begin
      return SRC_ALEXA;
    end
    return SRC_TV;
  endfunction

endpackage

// File: rtl/prior_som_sync.sv
// rtl/prior_som_sync.sv - two-flop synchronizer bank for asynchronous request lines
module prior_som_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/prior_som.sv
// rtl/prior_som.sv - priority audio source selector with dwell time; PRIOR_SOM_STATUS_EN adds sel/switch_cnt
module prior_som
  import prior_som_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  output logic       TV,
  output logic       PC,
  output logic       ALEXA
`ifdef PRIOR_SOM_STATUS_EN
  ,
  output logic [1:0] sel,
  output logic [7:0] switch_cnt
`endif
);

  localparam logic [7:0] HOLD_L = HOLD_CYCLES[7:0];

  logic [1:0] w_req_s;
  src_e       w_target;
  logic       w_change;

  src_e       r_state;
  logic [7:0] r_hold;
  logic       r_tv;
  logic       r_pc;
  logic       r_alexa;

  prior_som_sync #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({A, B}),
    .o_q   (w_req_s)
  );

  assign w_target = decode_target(w_req_s[1], w_req_s[0]);
  // Requests seen while the dwell timer runs are simply not acted on.
  assign w_change = (w_target != r_state) && (r_hold == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SRC_TV;
      r_hold  <= 8'd0;
      r_tv    <= 1'b1;
      r_pc    <= 1'b0;
      r_alexa <= 1'b0;
    end else if (w_change) begin
      r_state <= w_target;
      r_hold  <= HOLD_L;
      r_tv    <= (w_target == SRC_TV);
      r_pc    <= (w_target == SRC_PC);
      r_alexa <= (w_target == SRC_ALEXA);
    end else if (r_hold != 8'd0) begin
      r_hold <= r_hold - 8'd1;
    end
  end

  assign TV    = r_tv;
  assign PC    = r_pc;
  assign ALEXA = r_alexa;

`ifdef PRIOR_SOM_STATUS_EN
  logic [7:0] r_switch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_switch_cnt <= 8'd0;
    end else if (w_change && (r_switch_cnt != 8'hff)) begin
      r_switch_cnt <= r_switch_cnt + 8'd1;
    end
  end

  assign sel        = r_state;
  assign switch_cnt = r_switch_cnt;
`endif

endmodule

// File: tb/tb_prior_som.sv
// tb/tb_prior_som.sv - self-checking bench for prior_som (HOLD_CYCLES=4 and 0 instances)
module tb_prior_som;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ia = 2'b00;
  logic [1:0] ib = 2'b00;
  logic [1:0] w_tv, w_pc, w_al;
`ifdef PRIOR_SOM_STATUS_EN
  logic [1:0] w_sel [2];
  logic [7:0] w_cnt [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prior_som #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(ia[0]), .B(ib[0]),
    .TV(w_tv[0]), .PC(w_pc[0]), .ALEXA(w_al[0])
`ifdef PRIOR_SOM_STATUS_EN
    , .sel(w_sel[0]), .switch_cnt(w_cnt[0])
`endif
  );

  prior_som #(.HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .A(ia[1]), .B(ib[1]),
    .TV(w_tv[1]), .PC(w_pc[1]), .ALEXA(w_al[1])
`ifdef PRIOR_SOM_STATUS_EN
    , .sel(w_sel[1]), .switch_cnt(w_cnt[1])
`endif
  );

  // Reference model: 0=TV 1=PC 2=ALEXA; a request reaches the decision two edges
  // after it is sampled, and a switch is allowed only once more than hold edges
  // have passed since the previous switch.
  int         m_st   [2] = '{0, 0};
  int         m_last [2] = '{-1000, -1000};
  int         m_sw   [2] = '{0, 0};
  int         m_cyc = 0;
  logic [1:0] m_h1   [2] = '{2'b00, 2'b00};
  logic [1:0] m_h2   [2] = '{2'b00, 2'b00};

  function automatic int tgt_of(input logic [1:0] ab);
    return ab[1] ? 1 : (ab[0] ? 2 : 0);
  endfunction

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_h1[i] <= 2'b00; m_h2[i] <= 2'b00; m_st[i] <= 0; m_last[i] <= -1000; m_sw[i] <= 0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        m_h2[i] <= m_h1[i];
        m_h1[i] <= {ia[i], ib[i]};
        if (tgt_of(m_h2[i]) != m_st[i] && (m_cyc - m_last[i]) > hold_of(i)) begin
          m_st[i]   <= tgt_of(m_h2[i]);
          m_last[i] <= m_cyc;
          m_sw[i]   <= (m_sw[i] >= 255) ? 255 : m_sw[i] + 1;
        end
      end
    end
  end

  function automatic logic [2:0] exp_out(input int st);
    return {st == 0, st == 1, st == 2};
  endfunction

  function automatic logic [2:0] got(input int i);
    return {w_tv[i], w_pc[i], w_al[i]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ia = 2'b00; ib = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got(i) !== 3'b100) begin n_bad++; $display("FAIL reset_out[%0d] got %b want 100", i, got(i)); end
`ifdef PRIOR_SOM_STATUS_EN
      n_cmp++;
      if (w_sel[i] !== 2'b00 || w_cnt[i] !== 8'd0) begin
        n_bad++; $display("FAIL reset_status[%0d] got sel=%b cnt=%0d want 00/0", i, w_sel[i], w_cnt[i]);
      end
`endif
    end
    rst_n = 1'b1;
    ia[0] = 1'b1;
    for (int c = 0; c < 10 && got(0) !== 3'b010; c++) @(negedge clk);
    n_cmp++;
    if (got(0) !== 3'b010) begin n_bad++; $display("FAIL reset_pre_pc got %b want 010", got(0)); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got(0) !== 3'b100) begin n_bad++; $display("FAIL reset_async got %b want 100", got(0)); end
`ifdef PRIOR_SOM_STATUS_EN
    n_cmp++;
    if (w_sel[0] !== 2'b00 || w_cnt[0] !== 8'd0) begin
      n_bad++; $display("FAIL reset_async_status got sel=%b cnt=%0d want 00/0", w_sel[0], w_cnt[0]);
    end
`endif
    @(negedge clk);
    ia[0] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] p;
    logic [2:0] want;
    for (int seg = 0; seg < 8; seg++) begin
      p = (seg < 4) ? 2'(seg) : 2'($urandom_range(0, 3));
      ia[0] = p[1]; ib[0] = p[0];
      repeat (20) begin
        @(negedge clk);
        n_cmp++;
        if (got(0) !== exp_out(m_st[0]) || $countones(got(0)) != 1) begin
          n_bad++; $display("FAIL truth_cycle AB=%b got %b want %b", p, got(0), exp_out(m_st[0]));
        end
      end
      want = (p == 2'b00) ? 3'b100 : (p == 2'b01) ? 3'b001 : 3'b010;
      n_cmp++;
      if (got(0) !== want) begin n_bad++; $display("FAIL truth_table AB=%b got %b want %b", p, got(0), want); end
    end
  endtask

  task automatic test_latency();
    ia[0] = 1'b0; ib[0] = 1'b0;
    repeat (12) @(negedge clk);
    ia[0] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      n_cmp++;
      if (got(0) !== ((e < 2) ? 3'b100 : 3'b010)) begin
        n_bad++; $display("FAIL latency edge k+%0d got %b want %b", e, got(0), (e < 2) ? 3'b100 : 3'b010);
      end
    end
  endtask

  task automatic test_dwell();
    ia[0] = 1'b0; ib[0] = 1'b0;
    repeat (12) @(negedge clk);
    ib[0] = 1'b1;
    for (int c = 0; c < 10 && got(0) !== 3'b001; c++) @(negedge clk);
    n_cmp++;
    if (got(0) !== 3'b001) begin n_bad++; $display("FAIL dwell_to_alexa got %b want 001", got(0)); end
    ia[0] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (got(0) !== ((j < 5) ? 3'b001 : 3'b010) || got(0) !== exp_out(m_st[0])) begin
        n_bad++; $display("FAIL dwell edge e+%0d got %b want %b", j, got(0), (j < 5) ? 3'b001 : 3'b010);
      end
    end
  endtask

  task automatic test_dropped();
    int base;
    ia[0] = 1'b0; ib[0] = 1'b0;
    repeat (12) @(negedge clk);
    base = m_sw[0];
    ib[0] = 1'b1;
    for (int c = 0; c < 10 && got(0) !== 3'b001; c++) @(negedge clk);
    ia[0] = 1'b1;
    repeat (2) @(negedge clk);
    ia[0] = 1'b0;
    for (int j = 0; j < 15; j++) begin
      n_cmp++;
      if (got(0) !== 3'b001) begin n_bad++; $display("FAIL dropped cycle %0d got %b want 001", j, got(0)); end
      @(negedge clk);
    end
`ifdef PRIOR_SOM_STATUS_EN
    n_cmp++;
    if (w_cnt[0] !== 8'(base + 1)) begin
      n_bad++; $display("FAIL dropped_count got %0d want %0d", w_cnt[0], base + 1);
    end
`endif
  endtask

  task automatic test_hold0_alternate();
    logic [2:0] prev;
    logic [2:0] nxt;
    ia[1] = 1'b0; ib[1] = 1'b0;
    repeat (6) @(negedge clk);
    prev = 3'b100;
    for (int seg = 0; seg < 310; seg++) begin
      ia[1] = seg[0]; ib[1] = ~seg[0];
      nxt = seg[0] ? 3'b010 : 3'b001;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_cmp++;
        if (got(1) !== ((c < 2) ? prev : nxt)) begin
          n_bad++; $display("FAIL hold0 seg %0d edge+%0d got %b want %b", seg, c, got(1), (c < 2) ? prev : nxt);
        end
      end
      prev = nxt;
    end
`ifdef PRIOR_SOM_STATUS_EN
    n_cmp++;
    if (w_cnt[1] !== 8'd255) begin n_bad++; $display("FAIL hold0_saturate got %0d want 255", w_cnt[1]); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ia[i] = 1'($urandom); ib[i] = 1'($urandom);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got(i) !== exp_out(m_st[i]) || $countones(got(i)) != 1) begin
          n_bad++; $display("FAIL random[%0d] cycle %0d got %b want %b", i, c, got(i), exp_out(m_st[i]));
        end
`ifdef PRIOR_SOM_STATUS_EN
        n_cmp++;
        if (w_sel[i] !== 2'(m_st[i]) || w_cnt[i] !== 8'(m_sw[i])) begin
          n_bad++; $display("FAIL random_status[%0d] got sel=%b cnt=%0d want %0d/%0d",
                            i, w_sel[i], w_cnt[i], m_st[i], m_sw[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_latency();
    test_dwell();
    test_dropped();
    test_hold0_alternate();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
